ctrl_unit_pipe: RTL and testbench
=================================

Name: ctrl_unit_pipe

Overview:
- Pipelined MIPS control unit: decodes the ID-stage instruction and registers the control bundle into ID/EX.
- Carries write-back control through EX/MEM/WB.
- Detects load-use hazards (stall) and taken-branch flushes, and produces registered ALU operand forwarding selects.
- Sits between the IF/ID register and the datapath. Successor to the single-stage decoder: adds hazard, flush and forwarding logic, plus correct BNE, SLLV/SRLV/SRAV and zero-extend decoding.

Parameters:
- REG_AW, 5, register address width.
- ALUC_W, 4, ALU op code width (codes from the shared ALU_* constants).
- FLUSH_SLOTS, 1, number of ID/EX bubbles inserted after a taken branch (1..3).
- FWD_EN, 1, 1 = forwarding selects computed; 0 = selects tied to 0 and every RAW hazard stalls.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instr  in  32  ID-stage instruction
- instr_valid  in  1  instr holds a real instruction
- branch_taken  in  1  EX-stage branch compare result (qualified by ex_branch)
- stall  out  1  combinational; hold PC and IF/ID
- flush  out  1  combinational; squash IF/ID
- id_jump  out  1  combinational; J/JAL/JR in ID
- id_jr  out  1  combinational; JR in ID
- id_sext  out  1  combinational; immediate sign-extend
- ex_branch, ex_bne, ex_wreg, ex_m2reg, ex_wmem, ex_shift, ex_aluimm, ex_lui, ex_jal  out  1 each  ID/EX control
- ex_aluc  out  ALUC_W  ALU op
- ex_dst  out  REG_AW  destination register
- fwd_a, fwd_b  out  2 each  00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result
- mem_wreg, mem_m2reg, mem_wmem  out  1 each  EX/MEM control
- mem_dst  out  REG_AW  EX/MEM destination
- wb_wreg, wb_m2reg  out  1 each  MEM/WB control
- wb_dst  out  REG_AW  MEM/WB destination
- illegal  out  1  registered pulse on an undecodable opcode/func

Behaviour:
- **Reset:** synchronous, rst_n low at posedge clk clears all registered outputs and the flush counter to 0. Combinational outputs follow from the cleared state.
- **Pipeline:** control advances ID→EX→MEM→WB, one stage per clock, with no back-pressure except stall. Decode-to-ex_* latency is 1 cycle.
- **Decode:**
  - Branch: BEQ gives branch=1, bne=0; BNE gives branch=1, bne=1.
  - Register writes: wreg=0 for SW, BEQ, BNE, J, JR; wreg=1 otherwise.
  - Memory: m2reg=1 for LW only; wmem=1 for SW only.
  - Shift: shift=1 for SLL/SRL/SRA only. SLLV/SRLV/SRAV give shift=0 with aluc = SLL/SRL/SRA respectively.
  - aluimm=0 for R-type, BEQ, BNE; 1 otherwise.
  - id_sext=0 for ANDI/ORI/XORI only.
- **Destination:**
  - R-type: rd.
  - I-type: rt.
  - JAL: 31.
  - Any wreg=0 instruction: 0.
  - A destination of 0 always forces wreg=0.
- **Source use:**
  - rs is used by R-type (except SLL/SRL/SRA), I-type arithmetic, LW, SW, BEQ, BNE, JR.
  - rt is used by R-type, SW, BEQ, BNE.
- **Load-use:** stall=1 when all hold:
  - ex_m2reg=1, and
  - ex_dst≠0, and
  - ex_dst matches a used ID source.
  
  On stall, ID/EX loads a bubble (all controls 0) and the ID instruction is re-presented next cycle. Stall lasts one cycle per hazard.
- **FWD_EN=0:** stall also asserts when ex_dst or mem_dst (with its wreg=1) matches a used source.
- **Forwarding:** computed at ID against the EX and MEM stages and registered with the bundle.
  - 01 when the EX-stage instruction writes the matching register.
  - 10 when the MEM stage writes it.
  - 01 wins over 10.
  - Register 0 never forwards.
- **Flush:**
  - Trigger: ex_branch & (branch_taken ^ ex_bne) asserts flush and loads the counter with FLUSH_SLOTS.
  - While the counter is non-zero, ID/EX loads bubbles and the counter decrements.
  - Flush has priority over stall: stall=0 whenever flush is asserted or the counter is non-zero.
  - A branch in a bubble never triggers.
- **Jumps:** id_jump and id_jr are decoded combinationally and are suppressed (0) during stall or flush. The PC logic resolves jumps in ID.
- **Invalid input:** instr_valid=0 or an illegal instruction inserts a bubble. illegal pulses for 1 cycle only for an illegal instruction with instr_valid=1.
- **Reset mid-flush:** clears the counter; the next valid instruction decodes normally.

Decomposition:
- Shared package macro.vh holds OP_*, FUNC_*, ALU_* constants, plus new FWD_RF/FWD_EXMEM/FWD_MEMWB codes and CTRL_BUNDLE_W.
- One sub-module, ctrl_decode: purely combinational instr → control bundle, dst, rs_used, rt_used, illegal.
- Hazard, forwarding and stage registers live in ctrl_unit_pipe.

Test Plan:
- **Reset:** hold rst_n=0 for 2 clocks with instr=ADD → all ex_/mem_/wb_ outputs 0, stall=0, flush=0. After release, ex_aluc=ALU_ADD, ex_dst=rd one cycle later.
- **Load-use:** LW $2,0($1) then ADD $3,$2,$4 → stall=1 for exactly 1 cycle, one bubble in EX, ADD reaches EX with fwd_a=10.
- **Forwarding priority:** ADD $5,.. ; ADD $5,.. ; SUB $6,$5,$5 → SUB in EX has fwd_a=fwd_b=01. A $0 destination gives 00.
- **Branch:**
  - BNE with branch_taken=0 and FLUSH_SLOTS=2 → flush=1, two bubbles, counter returns to 0.
  - BEQ with branch_taken=0 → no flush.
- **Flush vs stall:** taken branch in EX while ID holds a load-use consumer → flush=1, stall=0. Reset asserted mid-flush clears the counter.
- **Decode corners:**
  - ORI → id_sext=0.
  - SRAV → ex_shift=0, ex_aluc=ALU_SRA.
  - JAL → ex_dst=31.
  - Undefined opcode 6'h3F → illegal=1 pulse, bubble.

Source files
------------

// File: rtl/ctrl_unit_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ctrl_unit_pipe_pkg                                          |
// | Purpose : Shared MIPS opcode/function/ALU codes, forwarding select     |
// |           codes and the decoded control bundle type.                  |
// | Ports   : none (package)                                              |
// | Rev     : 1.0  initial pipelined control unit release                 |
// +----------------------------------------------------------------------+
package ctrl_unit_pipe_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FUNC_SLL  = 6'h00;
  localparam logic [5:0] FUNC_SRL  = 6'h02;
  localparam logic [5:0] FUNC_SRA  = 6'h03;
  localparam logic [5:0] FUNC_SLLV = 6'h04;
  localparam logic [5:0] FUNC_SRLV = 6'h06;
  localparam logic [5:0] FUNC_SRAV = 6'h07;
  localparam logic [5:0] FUNC_JR   = 6'h08;
  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] FUNC_SUB  = 6'h22;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;
  localparam logic [5:0] FUNC_XOR  = 6'h26;

  // ALU operation codes; 0 is reserved so a bubble is distinguishable
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_OR  = 4'h4;
  localparam logic [3:0] ALU_XOR = 4'h5;
  localparam logic [3:0] ALU_LUI = 4'h6;
  localparam logic [3:0] ALU_SLL = 4'h7;
  localparam logic [3:0] ALU_SRL = 4'h8;
  localparam logic [3:0] ALU_SRA = 4'h9;

  // ALU operand forwarding selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Single-bit decoded controls; jump/jr/sext are consumed in ID only
  typedef struct packed {
    logic branch;
    logic bne;
    logic wreg;
    logic m2reg;
    logic wmem;
    logic shift;
    logic aluimm;
    logic lui;
    logic jal;
    logic jump;
    logic jr;
    logic sext;
  } ctrl_t;

  localparam int CTRL_BUNDLE_W = $bits(ctrl_t);

endpackage
`default_nettype wire

// File: rtl/ctrl_unit_pipe_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ctrl_decode                                                 |
// | Purpose : Purely combinational MIPS instruction decoder.              |
// | Ports   : instr   - ID-stage instruction                              |
// |           ctl     - decoded single-bit control bundle                 |
// |           aluc    - ALU operation code                                |
// |           dst     - destination register (0 when nothing is written)  |
// |           rs_used / rt_used - source register fields actually read    |
// |           illegal - opcode/func not recognised                        |
// | Rev     : 1.0  initial pipelined control unit release                 |
// +----------------------------------------------------------------------+
module ctrl_decode
  import ctrl_unit_pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4
) (
  input  logic [31:0]       instr,
  output ctrl_t             ctl,
  output logic [ALUC_W-1:0] aluc,
  output logic [REG_AW-1:0] dst,
  output logic              rs_used,
  output logic              rt_used,
  output logic              illegal
);

  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [3:0] alu_op;
  logic [4:0] dst_raw;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign func          = instr[5:0];
  assign rt            = instr[20:16];
  assign rd            = instr[15:11];
  // rs is compared in the hazard logic; shamt goes straight to the datapath
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    ctl      = '0;
    ctl.sext = 1'b1;
    alu_op   = ALU_ADD;
    dst_raw  = 5'd0;
    rs_used  = 1'b0;
    rt_used  = 1'b0;
    illegal  = 1'b0;

    case (op)
      OP_RTYPE: begin
        ctl.wreg = 1'b1;
        dst_raw  = rd;
        rs_used  = 1'b1;
        rt_used  = 1'b1;
        case (func)
          FUNC_ADD:  alu_op = ALU_ADD;
          FUNC_SUB:  alu_op = ALU_SUB;
          FUNC_AND:  alu_op = ALU_AND;
          FUNC_OR:   alu_op = ALU_OR;
          FUNC_XOR:  alu_op = ALU_XOR;
          // Immediate shifts take the amount from shamt, so rs is not read
          FUNC_SLL: begin alu_op = ALU_SLL; ctl.shift = 1'b1; rs_used = 1'b0; end
          FUNC_SRL: begin alu_op = ALU_SRL; ctl.shift = 1'b1; rs_used = 1'b0; end
          FUNC_SRA: begin alu_op = ALU_SRA; ctl.shift = 1'b1; rs_used = 1'b0; end
          // Variable shifts take the amount from rs through the normal A path
          FUNC_SLLV: alu_op = ALU_SLL;
          FUNC_SRLV: alu_op = ALU_SRL;
          FUNC_SRAV: alu_op = ALU_SRA;
          FUNC_JR: begin
            ctl.wreg = 1'b0;
            ctl.jump = 1'b1;
            ctl.jr   = 1'b1;
            dst_raw  = 5'd0;
            rt_used  = 1'b0;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        ctl.wreg = 1'b1; ctl.aluimm = 1'b1; dst_raw = rt; rs_used = 1'b1;
        alu_op   = ALU_ADD;
      end
      OP_ANDI: begin
        ctl.wreg = 1'b1; ctl.aluimm = 1'b1; dst_raw = rt; rs_used = 1'b1;
        ctl.sext = 1'b0; alu_op = ALU_AND;
      end
      OP_ORI: begin
        ctl.wreg = 1'b1; ctl.aluimm = 1'b1; dst_raw = rt; rs_used = 1'b1;
        ctl.sext = 1'b0; alu_op = ALU_OR;
      end
      OP_XORI: begin
        ctl.wreg = 1'b1; ctl.aluimm = 1'b1; dst_raw = rt; rs_used = 1'b1;
        ctl.sext = 1'b0; alu_op = ALU_XOR;
      end
      OP_LUI: begin
        ctl.wreg = 1'b1; ctl.aluimm = 1'b1; ctl.lui = 1'b1; dst_raw = rt;
        alu_op   = ALU_LUI;
      end
      OP_LW: begin
        ctl.wreg = 1'b1; ctl.m2reg = 1'b1; ctl.aluimm = 1'b1; dst_raw = rt;
        rs_used  = 1'b1; alu_op = ALU_ADD;
      end
      OP_SW: begin
        ctl.wmem = 1'b1; ctl.aluimm = 1'b1; rs_used = 1'b1; rt_used = 1'b1;
        alu_op   = ALU_ADD;
      end
      OP_BEQ: begin
        ctl.branch = 1'b1; rs_used = 1'b1; rt_used = 1'b1; alu_op = ALU_SUB;
      end
      OP_BNE: begin
        ctl.branch = 1'b1; ctl.bne = 1'b1; rs_used = 1'b1; rt_used = 1'b1;
        alu_op     = ALU_SUB;
      end
      OP_J: begin
        ctl.jump = 1'b1; ctl.aluimm = 1'b1;
      end
      OP_JAL: begin
        ctl.jump = 1'b1; ctl.jal = 1'b1; ctl.wreg = 1'b1; ctl.aluimm = 1'b1;
        dst_raw  = 5'd31;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      ctl      = '0;
      ctl.sext = 1'b1;
      alu_op   = 4'd0;
      dst_raw  = 5'd0;
      rs_used  = 1'b0;
      rt_used  = 1'b0;
    end

    // Writes to $0 are architecturally discarded; dropping wreg here keeps
    // them out of forwarding and hazard comparisons downstream.
    if (dst_raw == 5'd0) begin
      ctl.wreg = 1'b0;
    end
  end

  assign aluc = ALUC_W'(alu_op);
  assign dst  = REG_AW'(dst_raw);

endmodule
`default_nettype wire

// File: rtl/ctrl_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ctrl_unit_pipe                                              |
// | Purpose : Pipelined MIPS control unit: ID decode into ID/EX, write-   |
// |           back control through EX/MEM/WB, load-use stall, taken-      |
// |           branch flush and registered operand forwarding selects.     |
// | Ports   : clk, rst_n (sync active-low), instr/instr_valid (ID),       |
// |           branch_taken (EX compare), stall/flush/id_* (comb, ID),     |
// |           ex_* / fwd_* (ID/EX), mem_* (EX/MEM), wb_* (MEM/WB),        |
// |           illegal (registered pulse)                                  |
// | Rev     : 1.0  initial pipelined control unit release                 |
// +----------------------------------------------------------------------+
module ctrl_unit_pipe
  import ctrl_unit_pipe_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int ALUC_W      = 4,
  parameter int FLUSH_SLOTS = 1,
  parameter int FWD_EN      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              branch_taken,
  output logic              stall,
  output logic              flush,
  output logic              id_jump,
  output logic              id_jr,
  output logic              id_sext,
  output logic              ex_branch,
  output logic              ex_bne,
  output logic              ex_wreg,
  output logic              ex_m2reg,
  output logic              ex_wmem,
  output logic              ex_shift,
  output logic              ex_aluimm,
  output logic              ex_lui,
  output logic              ex_jal,
  output logic [ALUC_W-1:0] ex_aluc,
  output logic [REG_AW-1:0] ex_dst,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_wreg,
  output logic              mem_m2reg,
  output logic              mem_wmem,
  output logic [REG_AW-1:0] mem_dst,
  output logic              wb_wreg,
  output logic              wb_m2reg,
  output logic [REG_AW-1:0] wb_dst,
  output logic              illegal
);

  ctrl_t             dec_ctl;
  logic [ALUC_W-1:0] dec_aluc;
  logic [REG_AW-1:0] dec_dst;
  logic              dec_rs_used;
  logic              dec_rt_used;
  logic              dec_illegal;

  ctrl_decode #(
    .REG_AW (REG_AW),
    .ALUC_W (ALUC_W)
  ) u_decode (
    .instr   (instr),
    .ctl     (dec_ctl),
    .aluc    (dec_aluc),
    .dst     (dec_dst),
    .rs_used (dec_rs_used),
    .rt_used (dec_rt_used),
    .illegal (dec_illegal)
  );

  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [1:0]        flush_cnt;
  logic              flush_trig;
  logic              flush_busy;
  logic              use_rs, use_rt;
  logic              ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic              load_use;
  logic              raw_stall;
  logic [1:0]        fwd_a_nxt, fwd_b_nxt;
  logic              bubble;

  assign rs_addr = REG_AW'(instr[25:21]);
  assign rt_addr = REG_AW'(instr[20:16]);

  // ex_* are already bubble-cleared, so a squashed branch can never fire.
  // branch_taken is the equality result; BNE redirects when it is false.
  assign flush_trig = ex_branch & (branch_taken ^ ex_bne);
  assign flush_busy = flush_trig | (flush_cnt != 2'd0);
  assign flush      = flush_trig;

  assign use_rs = instr_valid & dec_rs_used;
  assign use_rt = instr_valid & dec_rt_used;

  // Register 0 is never a real producer, so it never matches.
  assign ex_hit_rs  = use_rs && (ex_dst  != '0) && (ex_dst  == rs_addr);
  assign ex_hit_rt  = use_rt && (ex_dst  != '0) && (ex_dst  == rt_addr);
  assign mem_hit_rs = use_rs && (mem_dst != '0) && (mem_dst == rs_addr);
  assign mem_hit_rt = use_rt && (mem_dst != '0) && (mem_dst == rt_addr);

  // Load data only exists after MEM, too late to forward into the next EX.
  assign load_use = ex_m2reg & (ex_hit_rs | ex_hit_rt);

  generate
    if (FWD_EN != 0) begin : g_fwd
      // The EX-stage producer is younger than the MEM-stage one, so it wins.
      assign fwd_a_nxt = (ex_wreg  & ex_hit_rs)  ? FWD_EXMEM :
                         (mem_wreg & mem_hit_rs) ? FWD_MEMWB : FWD_RF;
      assign fwd_b_nxt = (ex_wreg  & ex_hit_rt)  ? FWD_EXMEM :
                         (mem_wreg & mem_hit_rt) ? FWD_MEMWB : FWD_RF;
      assign raw_stall = 1'b0;
    end else begin : g_nofwd
      assign fwd_a_nxt = FWD_RF;
      assign fwd_b_nxt = FWD_RF;
      assign raw_stall = (ex_wreg  & (ex_hit_rs  | ex_hit_rt)) |
                         (mem_wreg & (mem_hit_rs | mem_hit_rt));
    end
  endgenerate

  // A flushing pipeline discards the ID instruction anyway, so holding it is
  // pointless and could deadlock against the redirect.
  assign stall = ~flush_busy & (load_use | raw_stall);

  // The instruction sitting in ID when the branch resolves proceeds; the
  // FLUSH_SLOTS slots after it are replaced by bubbles.
  assign bubble = stall | (flush_cnt != 2'd0) | ~instr_valid | dec_illegal;

  assign id_jump = dec_ctl.jump & instr_valid & ~stall & ~flush_busy;
  assign id_jr   = dec_ctl.jr   & instr_valid & ~stall & ~flush_busy;
  assign id_sext = dec_ctl.sext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_branch <= 1'b0;
      ex_bne    <= 1'b0;
      ex_wreg   <= 1'b0;
      ex_m2reg  <= 1'b0;
      ex_wmem   <= 1'b0;
      ex_shift  <= 1'b0;
      ex_aluimm <= 1'b0;
      ex_lui    <= 1'b0;
      ex_jal    <= 1'b0;
      ex_aluc   <= '0;
      ex_dst    <= '0;
      fwd_a     <= FWD_RF;
      fwd_b     <= FWD_RF;
      mem_wreg  <= 1'b0;
      mem_m2reg <= 1'b0;
      mem_wmem  <= 1'b0;
      mem_dst   <= '0;
      wb_wreg   <= 1'b0;
      wb_m2reg  <= 1'b0;
      wb_dst    <= '0;
      illegal   <= 1'b0;
      flush_cnt <= 2'd0;
    end else begin
      if (bubble) begin
        ex_branch <= 1'b0;
        ex_bne    <= 1'b0;
        ex_wreg   <= 1'b0;
        ex_m2reg  <= 1'b0;
        ex_wmem   <= 1'b0;
        ex_shift  <= 1'b0;
        ex_aluimm <= 1'b0;
        ex_lui    <= 1'b0;
        ex_jal    <= 1'b0;
        ex_aluc   <= '0;
        ex_dst    <= '0;
        fwd_a     <= FWD_RF;
        fwd_b     <= FWD_RF;
      end else begin
        ex_branch <= dec_ctl.branch;
        ex_bne    <= dec_ctl.bne;
        ex_wreg   <= dec_ctl.wreg;
        ex_m2reg  <= dec_ctl.m2reg;
        ex_wmem   <= dec_ctl.wmem;
        ex_shift  <= dec_ctl.shift;
        ex_aluimm <= dec_ctl.aluimm;
        ex_lui    <= dec_ctl.lui;
        ex_jal    <= dec_ctl.jal;
        ex_aluc   <= dec_aluc;
        ex_dst    <= dec_dst;
        fwd_a     <= fwd_a_nxt;
        fwd_b     <= fwd_b_nxt;
      end

      mem_wreg  <= ex_wreg;
      mem_m2reg <= ex_m2reg;
      mem_wmem  <= ex_wmem;
      mem_dst   <= ex_dst;

      wb_wreg   <= mem_wreg;
      wb_m2reg  <= mem_m2reg;
      wb_dst    <= mem_dst;

      illegal   <= instr_valid & dec_illegal;

      if (flush_trig) begin
        flush_cnt <= 2'(FLUSH_SLOTS);
      end else if (flush_cnt != 2'd0) begin
        flush_cnt <= flush_cnt - 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ctrl_unit_pipe                                           |
// | Purpose : Directed self-checking bench for ctrl_unit_pipe with        |
// |           FLUSH_SLOTS=2 and forwarding enabled.                       |
// | Ports   : none                                                        |
// | Rev     : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_ctrl_unit_pipe;
  import ctrl_unit_pipe_pkg::*;

  localparam int REG_AW = 5;
  localparam int ALUC_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              branch_taken;
  logic              stall, flush, id_jump, id_jr, id_sext;
  logic              ex_branch, ex_bne, ex_wreg, ex_m2reg, ex_wmem;
  logic              ex_shift, ex_aluimm, ex_lui, ex_jal;
  logic [ALUC_W-1:0] ex_aluc;
  logic [REG_AW-1:0] ex_dst;
  logic [1:0]        fwd_a, fwd_b;
  logic              mem_wreg, mem_m2reg, mem_wmem;
  logic [REG_AW-1:0] mem_dst;
  logic              wb_wreg, wb_m2reg;
  logic [REG_AW-1:0] wb_dst;
  logic              illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ctrl_unit_pipe #(
    .REG_AW      (REG_AW),
    .ALUC_W      (ALUC_W),
    .FLUSH_SLOTS (2),
    .FWD_EN      (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .branch_taken (branch_taken),
    .stall        (stall),
    .flush        (flush),
    .id_jump      (id_jump),
    .id_jr        (id_jr),
    .id_sext      (id_sext),
    .ex_branch    (ex_branch),
    .ex_bne       (ex_bne),
    .ex_wreg      (ex_wreg),
    .ex_m2reg     (ex_m2reg),
    .ex_wmem      (ex_wmem),
    .ex_shift     (ex_shift),
    .ex_aluimm    (ex_aluimm),
    .ex_lui       (ex_lui),
    .ex_jal       (ex_jal),
    .ex_aluc      (ex_aluc),
    .ex_dst       (ex_dst),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mem_wreg     (mem_wreg),
    .mem_m2reg    (mem_m2reg),
    .mem_wmem     (mem_wmem),
    .mem_dst      (mem_dst),
    .wb_wreg      (wb_wreg),
    .wb_m2reg     (wb_m2reg),
    .wb_dst       (wb_dst),
    .illegal      (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input logic [5:0] func);
    rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, func};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    itype = {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Drive the ID inputs just after an edge and let combinational outputs settle.
  task automatic apply(input logic [31:0] ins, input logic bt, input logic rn);
    instr        = ins;
    instr_valid  = 1'b1;
    branch_taken = bt;
    rst_n        = rn;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // All registered stage outputs packed together for reset/bubble checks.
  function automatic logic [31:0] ex_vec();
    ex_vec = 32'({ex_branch, ex_bne, ex_wreg, ex_m2reg, ex_wmem, ex_shift,
                  ex_aluimm, ex_lui, ex_jal, ex_aluc, ex_dst, fwd_a, fwd_b});
  endfunction

  function automatic logic [31:0] all_regs();
    all_regs = ex_vec() ^ 32'({mem_wreg, mem_m2reg, mem_wmem, mem_dst,
                              wb_wreg, wb_m2reg, wb_dst, illegal}) ;
  endfunction

  initial begin
    // ---- reset held for two clocks with ADD $3,$1,$2 on the input
    apply(rtype(1, 2, 3, FUNC_ADD), 1'b0, 1'b0);
    tick();
    tick();
    check("rst_ex", ex_vec(), 32'd0);
    check("rst_mem_wb", 32'({mem_wreg, mem_m2reg, mem_wmem, mem_dst,
                             wb_wreg, wb_m2reg, wb_dst, illegal}), 32'd0);
    check("rst_stall_flush", {30'd0, stall, flush}, 32'd0);

    // ---- first instruction after release: 1-cycle decode latency
    apply(rtype(1, 2, 3, FUNC_ADD), 1'b0, 1'b1);
    tick();
    check("add_aluc", 32'(ex_aluc), 32'(ALU_ADD));
    check("add_dst", 32'(ex_dst), 32'd3);
    check("add_wreg", 32'(ex_wreg), 32'd1);

    // ---- load-use: LW $2,0($1) then ADD $3,$2,$4
    apply(itype(OP_LW, 1, 2, 16'h0000), 1'b0, 1'b1);
    tick();
    check("lw_ex", {ex_m2reg, ex_aluimm, 30'(ex_dst)}, {2'b11, 30'd2});
    apply(rtype(2, 4, 3, FUNC_ADD), 1'b0, 1'b1);
    check("lu_stall_on", 32'(stall), 32'd1);
    tick();
    check("lu_bubble", ex_vec(), 32'd0);
    check("lu_mem_lw", {mem_m2reg, 31'(mem_dst)}, {1'b1, 31'd2});
    check("lu_stall_off", 32'(stall), 32'd0);
    tick();
    check("lu_add_dst", 32'(ex_dst), 32'd3);
    check("lu_fwd", {fwd_a, fwd_b}, {FWD_MEMWB, FWD_RF});

    // ---- forwarding priority: EX/MEM beats MEM/WB
    apply(rtype(1, 1, 5, FUNC_ADD), 1'b0, 1'b1);
    tick();
    apply(rtype(2, 2, 5, FUNC_ADD), 1'b0, 1'b1);
    tick();
    apply(rtype(5, 5, 6, FUNC_SUB), 1'b0, 1'b1);
    tick();
    check("prio_fwd", {fwd_a, fwd_b}, {FWD_EXMEM, FWD_EXMEM});
    check("prio_sub", {28'(ex_aluc), 4'(ex_dst)}, {28'(ALU_SUB), 4'd6});

    // ---- $0 destination never writes and never forwards
    apply(rtype(1, 2, 0, FUNC_ADD), 1'b0, 1'b1);
    tick();
    check("r0_wreg", {ex_wreg, 31'(ex_dst)}, 32'd0);
    apply(rtype(0, 0, 7, FUNC_ADD), 1'b0, 1'b1);
    tick();
    check("r0_fwd", {fwd_a, fwd_b, 28'(ex_dst)}, {FWD_RF, FWD_RF, 28'd7});

    // ---- decode corners
    apply(itype(OP_ORI, 1, 8, 16'h00FF), 1'b0, 1'b1);
    check("ori_sext", 32'(id_sext), 32'd0);
    tick();
    check("ori_ex", {ex_aluimm, 27'(ex_aluc), 4'(ex_dst)}, {1'b1, 27'(ALU_OR), 4'd8});
    apply(rtype(2, 3, 9, FUNC_SRAV), 1'b0, 1'b1);
    check("srav_sext", 32'(id_sext), 32'd1);
    tick();
    check("srav_ex", {ex_shift, ex_aluimm, 26'(ex_aluc), 4'(ex_dst)},
          {1'b0, 1'b0, 26'(ALU_SRA), 4'd9});
    apply({OP_JAL, 26'h0000040}, 1'b0, 1'b1);
    check("jal_id_jump", {id_jump, id_jr}, 32'd2);
    tick();
    check("jal_ex", {ex_jal, ex_wreg, 30'(ex_dst)}, {1'b1, 1'b1, 30'd31});
    apply({6'h3F, 26'h0}, 1'b0, 1'b1);
    tick();
    check("illegal_pulse", 32'(illegal), 32'd1);
    check("illegal_bubble", ex_vec(), 32'd0);
    apply(itype(OP_ADDI, 0, 10, 16'h0005), 1'b0, 1'b1);
    tick();
    check("illegal_clear", {illegal, 31'(ex_dst)}, {1'b0, 31'd10});

    // ---- BNE with equal operands: redirects, two bubbles follow
    apply(itype(OP_BNE, 1, 2, 16'h0004), 1'b0, 1'b1);
    tick();
    check("bne_ex", {ex_branch, ex_bne}, 32'd3);
    apply(rtype(1, 1, 11, FUNC_ADD), 1'b0, 1'b1);
    check("bne_flush", {30'd0, flush, stall}, 32'd2);
    tick();
    apply({OP_J, 26'h0000100}, 1'b0, 1'b1);
    check("flush_jump_supp", {30'd0, id_jump, flush}, 32'd0);
    tick();
    check("flush_bubble1", ex_vec(), 32'd0);
    apply(rtype(1, 1, 13, FUNC_ADD), 1'b0, 1'b1);
    tick();
    check("flush_bubble2", ex_vec(), 32'd0);
    apply(rtype(1, 1, 14, FUNC_ADD), 1'b0, 1'b1);
    tick();
    check("flush_done", 32'(ex_dst), 32'd14);

    // ---- BEQ with equal=0: no redirect
    apply(itype(OP_BEQ, 1, 2, 16'h0004), 1'b0, 1'b1);
    tick();
    check("beq_ex", {ex_branch, ex_bne}, 32'd2);
    apply(rtype(1, 1, 15, FUNC_ADD), 1'b0, 1'b1);
    check("beq_noflush", 32'(flush), 32'd0);
    tick();
    check("beq_next", 32'(ex_dst), 32'd15);

    // ---- flush beats stall, then reset in the middle of the flush
    apply(itype(OP_BEQ, 1, 2, 16'h0004), 1'b0, 1'b1);
    tick();
    apply(itype(OP_LW, 1, 16, 16'h0000), 1'b1, 1'b1);
    check("beqt_flush", {30'd0, flush, stall}, 32'd2);
    tick();
    check("beqt_lw_ex", {ex_m2reg, 31'(ex_dst)}, {1'b1, 31'd16});
    apply(rtype(16, 16, 17, FUNC_ADD), 1'b0, 1'b0);
    check("flush_over_stall", {30'd0, stall, flush}, 32'd0);
    tick();
    check("midflush_rst", all_regs(), 32'd0);
    apply(rtype(1, 2, 18, FUNC_ADD), 1'b0, 1'b1);
    check("post_rst_stall", 32'(stall), 32'd0);
    tick();
    check("post_rst_decode", {ex_wreg, 31'(ex_dst)}, {1'b1, 31'd18});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
